// File: rtl/dec_pkg.sv
// Shared types, per-mode geometry and H-matrix construction for the
// streaming extended-Hamming SECDED decoder.
package dec_pkg;

  localparam int MAX_CW   = 32;  // widest codeword handled (26 info + 6 parity)
  localparam int MAX_P    = 6;   // widest syndrome
  localparam int MAX_INFO = 26;  // widest info field
  localparam int H_TBL_W  = MAX_CW * MAX_P;

  typedef enum logic [1:0] {
    MODE_8       = 2'b00,
    MODE_16      = 2'b01,
    MODE_32      = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2,
    ERR_UNCORR = 2'd3
  } err_t;

  localparam int INFO_W_8   = 4;
  localparam int PARITY_W_8 = 4;
  localparam int CW_W_8     = 8;

  localparam int INFO_W_16   = 11;
  localparam int PARITY_W_16 = 5;
  localparam int CW_W_16     = 16;

  localparam int INFO_W_32   = 26;
  localparam int PARITY_W_32 = 6;
  localparam int CW_W_32     = 32;

  // Stage-1 payload: the codeword plus its syndrome and what the syndrome decodes to.
  typedef struct packed {
    logic [MAX_CW-1:0] cw;
    mode_t             mode;
    logic [MAX_P-1:0]  syn;
    err_t              err;
    logic [MAX_CW-1:0] flip;
  } s1_t;

  // Column table for p parity bits, column i in bits [i*MAX_P +: MAX_P].
  // Parity columns are unit vectors; info columns walk the values >= 3 with
  // weight >= 2 in p-1 bits, topped up with bit p-1 so every column is odd.
  function automatic logic [H_TBL_W-1:0] h_table(input int p);
    logic [H_TBL_W-1:0] tbl;
    logic [MAX_P-1:0]   col;
    int                 k;
    tbl = '0;
    for (int i = 0; i < p; i++) begin
      col    = '0;
      col[i] = 1'b1;
      tbl[i*MAX_P +: MAX_P] = col;
    end
    k = p;
    for (int v = 3; v < (1 << (p - 1)); v++) begin
      col = MAX_P'(v);
      if ($countones(col) >= 2) begin
        if (($countones(col) % 2) == 0) col[p-1] = 1'b1;
        if (k < MAX_CW) tbl[k*MAX_P +: MAX_P] = col;
        k++;
      end
    end
    return tbl;
  endfunction

  localparam logic [H_TBL_W-1:0] H_TBL_8  = h_table(PARITY_W_8);
  localparam logic [H_TBL_W-1:0] H_TBL_16 = h_table(PARITY_W_16);
  localparam logic [H_TBL_W-1:0] H_TBL_32 = h_table(PARITY_W_32);

  // Info field sits directly above the parity bits; illegal mode yields zero.
  function automatic logic [MAX_INFO-1:0] extract_info(input mode_t m, input logic [MAX_CW-1:0] cw);
    logic [MAX_INFO-1:0] info;
    case (m)
      MODE_8:  info = MAX_INFO'(cw[CW_W_8-1:PARITY_W_8]);
      MODE_16: info = MAX_INFO'(cw[CW_W_16-1:PARITY_W_16]);
      MODE_32: info = MAX_INFO'(cw[CW_W_32-1:PARITY_W_32]);
      default: info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/dec_syndrome.sv
// Combinational syndrome, classification and single-bit flip mask for one
// codeword in the selected mode.
module dec_syndrome
  import dec_pkg::*;
(
  input  logic [MAX_CW-1:0] codeword,
  input  mode_t             mode,
  output logic [MAX_P-1:0]  syndrome,
  output err_t              err,
  output logic [MAX_CW-1:0] flip
);

  logic [H_TBL_W-1:0] tbl;
  int                 cw_w;

  // Select the column table and codeword length for this mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tbl  = '0;
    cw_w = 0;
    case (mode)
      MODE_8:  begin tbl = H_TBL_8;  cw_w = CW_W_8;  end
      MODE_16: begin tbl = H_TBL_16; cw_w = CW_W_16; end
      MODE_32: begin tbl = H_TBL_32; cw_w = CW_W_32; end
      default: ;
    endcase
  end

  // XOR the columns of all set codeword bits inside the mode's length.
  always_comb begin
    syndrome = '0;
    for (int i = 0; i < MAX_CW; i++) begin
      if (i < cw_w && codeword[i]) syndrome = syndrome ^ tbl[i*MAX_P +: MAX_P];
    end
  end

  // Mark the bit whose column equals the syndrome; columns are distinct and nonzero.
  always_comb begin
    flip = '0;
    for (int i = 0; i < MAX_CW; i++) begin
      if (i < cw_w && syndrome == tbl[i*MAX_P +: MAX_P]) flip[i] = 1'b1;
    end
  end

  // Classify: clean, correctable, even-weight double, or anything else.
  always_comb begin
    err = ERR_UNCORR;
    if (mode == MODE_ILLEGAL)  err = ERR_UNCORR;
    else if (syndrome == '0)   err = ERR_NONE;
    else if (|flip)            err = ERR_SINGLE;
    else if (!(^syndrome))     err = ERR_DOUBLE;
    else                       err = ERR_UNCORR;
  end

endmodule

// File: rtl/dec_secded_stream.sv
// Two-stage valid/ready SECDED decoder with saturating error statistics.
// Stage 1 holds codeword, mode and decoded syndrome; stage 2 holds the
// corrected info field and the error class.
module dec_secded_stream
  import dec_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [1:0]                    mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_INFO_WIDTH-1:0]     data_out,
  output logic [1:0]                    num_of_errors,
  input  logic                          cnt_clr,
  output logic [CNT_WIDTH-1:0]          cnt_corrected,
  output logic [CNT_WIDTH-1:0]          cnt_uncorrectable
);

  logic              s1_en;
  logic              s2_en;
  logic              s1_valid;
  s1_t               s1;
  s1_t               s1_d;
  logic [MAX_P-1:0]  syn_d;
  err_t              err_d;
  logic [MAX_CW-1:0] flip_d;
  logic [MAX_CW-1:0] corrected;
  logic              ev_corr;
  logic              ev_unc;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  dec_syndrome u_syndrome (
    .codeword (data_in[MAX_CW-1:0]),
    .mode     (mode_t'(mod)),
    .syndrome (syn_d),
    .err      (err_d),
    .flip     (flip_d)
  );

  assign s1_d = '{cw: data_in[MAX_CW-1:0], mode: mode_t'(mod), syn: syn_d, err: err_d, flip: flip_d};

  // A zero syndrome never selects a bit; uncorrectable words keep their flip mask empty.
  assign corrected = s1.cw ^ ((s1.syn != '0) ? s1.flip : '0);

  // Stage 1: capture an accepted word, hold while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: datapath registers are reset too, so a reset leaves no stale word visible.
    if (!rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_en) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      s1_valid <= in_valid;
      if (in_valid) s1 <= s1_d;
    end
  end

  // Stage 2: register corrected info and error class, stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      num_of_errors <= ERR_NONE;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out      <= MAX_INFO_WIDTH'(extract_info(s1.mode, corrected));
        num_of_errors <= s1.err;
      end
    end
  end

  assign ev_corr = out_valid && out_ready && (num_of_errors == ERR_SINGLE);
  assign ev_unc  = out_valid && out_ready && num_of_errors[1];

  // Corrected-word counter: saturating; a clear coinciding with an event restarts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt_corrected <= '0;
    else if (cnt_clr)                          cnt_corrected <= CNT_WIDTH'(ev_corr);
    else if (ev_corr && !(&cnt_corrected))     cnt_corrected <= cnt_corrected + 1'b1;
  end

  // Uncorrectable-word counter: same saturate/clear behaviour for classes 2 and 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt_uncorrectable <= '0;
    else if (cnt_clr)                          cnt_uncorrectable <= CNT_WIDTH'(ev_unc);
    else if (ev_unc && !(&cnt_uncorrectable))  cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
  end

endmodule

// File: tb/tb_dec_secded_stream.sv
// Directed bench for dec_secded_stream. A second instance with 2-bit
// counters shares the stimulus and is used for the saturation cases.
module tb_dec_secded_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [31:0] data_in;
  logic [1:0]  mod;

  logic        in_ready,  s_in_ready;
  logic        out_valid, s_out_valid;
  logic [25:0] data_out,  s_data_out;
  logic [1:0]  num_of_errors, s_num_of_errors;
  logic [15:0] cnt_corrected, cnt_uncorrectable;
  logic [1:0]  s_cnt_corrected, s_cnt_uncorrectable;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_secded_stream #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .mod(mod), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .num_of_errors(num_of_errors), .cnt_clr(cnt_clr), .cnt_corrected(cnt_corrected),
    .cnt_uncorrectable(cnt_uncorrectable)
  );

  dec_secded_stream #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .data_in(data_in),
    .mod(mod), .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out),
    .num_of_errors(s_num_of_errors), .cnt_clr(cnt_clr), .cnt_corrected(s_cnt_corrected),
    .cnt_uncorrectable(s_cnt_uncorrectable)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word into an idle pipeline and check it two edges later.
  task automatic decode_single(input string tag, input logic [31:0] cw, input logic [1:0] m,
                               input logic [25:0] exp_d, input logic [1:0] exp_e);
    data_in   = cw;
    mod       = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, data_out, exp_d);
    check({tag, "_err"}, num_of_errors, exp_e);
    check({tag, "_s_data"}, {s_out_valid, s_in_ready, s_num_of_errors, s_data_out}, {2'b11, exp_e, exp_d});
  endtask

  logic [31:0] bp_cw  [5];
  logic [1:0]  bp_mod [5];
  logic [25:0] bp_d   [5];
  logic [1:0]  bp_e   [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          sent, got, extra, ghost;
    logic        saw_full, prev_stall;
    logic [25:0] prev_d;
    logic [1:0]  prev_e;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    data_in = '0; mod = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_err", num_of_errors, 0);
    check("rst_cnt_corr", cnt_corrected, 0);
    check("rst_cnt_unc", cnt_uncorrectable, 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    tick();

    // Mode 00 clean, single, double
    decode_single("m0_clean", 32'h000000B1, 2'b00, 26'h00000B, 2'd0);
    decode_single("m0_single", 32'h00000091, 2'b00, 26'h00000B, 2'd1);
    tick();
    check("cnt_corr_1", cnt_corrected, 1);
    decode_single("m0_double", 32'h000000B2, 2'b00, 26'h00000B, 2'd2);
    tick();
    check("cnt_unc_1", cnt_uncorrectable, 1);

    // Mode 01 and mode 10
    decode_single("m1_clean", 32'h00000033, 2'b01, 26'h000001, 2'd0);
    decode_single("m1_single_par", 32'h00000037, 2'b01, 26'h000001, 2'd1);
    decode_single("m1_clean_top", 32'h0000801F, 2'b01, 26'h000400, 2'd0);
    decode_single("m2_clean", 32'h00000063, 2'b10, 26'h000001, 2'd0);
    decode_single("m2_double", 32'h00000060, 2'b10, 26'h000001, 2'd2);
    decode_single("m2_single_msb", 32'h0000001F, 2'b10, 26'h2000000, 2'd1);
    decode_single("m2_clean_msb", 32'h8000001F, 2'b10, 26'h2000000, 2'd0);
    tick();
    check("cnt_corr_3", cnt_corrected, 3);

    // Illegal mode
    decode_single("illegal", 32'hFFFFFFFF, 2'b11, 26'h0, 2'd3);
    tick();
    check("cnt_unc_3", cnt_uncorrectable, 3);

    // Backpressure stream with out_ready pattern 1,0,0,1
    bp_cw[0] = 32'h000000B1; bp_mod[0] = 2'b00; bp_d[0] = 26'h00000B;  bp_e[0] = 2'd0;
    bp_cw[1] = 32'h0000801F; bp_mod[1] = 2'b01; bp_d[1] = 26'h000400;  bp_e[1] = 2'd0;
    bp_cw[2] = 32'h000000C6; bp_mod[2] = 2'b10; bp_d[2] = 26'h000003;  bp_e[2] = 2'd0;
    bp_cw[3] = 32'h00000066; bp_mod[3] = 2'b01; bp_d[3] = 26'h000003;  bp_e[3] = 2'd0;
    bp_cw[4] = 32'h00000091; bp_mod[4] = 2'b00; bp_d[4] = 26'h00000B;  bp_e[4] = 2'd1;
    sent = 0; got = 0; saw_full = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_e = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (sent < 5) begin
        in_valid = 1'b1; data_in = bp_cw[sent]; mod = bp_mod[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", data_out, prev_d);
        check("bp_hold_err", num_of_errors, prev_e);
      end
      if (out_valid && !out_ready && !in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("bp_data_%0d", got), data_out, bp_d[got]);
        check($sformatf("bp_err_%0d", got), num_of_errors, bp_e[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_d     = data_out;
      prev_e     = num_of_errors;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 5);
    check("bp_full_stall_seen", saw_full, 1);
    extra = 0;
    repeat (4) begin
      if (out_valid) extra++;
      tick();
    end
    check("bp_no_dup", extra, 0);
    check("cnt_corr_4", cnt_corrected, 4);

    // Clear, then saturation on the 2-bit instance
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_corr", cnt_corrected, 0);
    check("clr_unc", cnt_uncorrectable, 0);
    in_valid = 1'b1; data_in = 32'h00000091; mod = 2'b00;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("sat_main_corr", cnt_corrected, 5);
    check("sat_small_corr", s_cnt_corrected, 3);

    // Clear coinciding with an accepted corrected word
    decode_single("clr_ev", 32'h00000091, 2'b00, 26'h00000B, 2'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_ev_main", cnt_corrected, 1);
    check("clr_ev_small", s_cnt_corrected, 1);
    check("clr_ev_unc", cnt_uncorrectable, 0);

    // Reset with two words in flight
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 32'h00000063; mod = 2'b10;
    tick();
    data_in = 32'h00000033; mod = 2'b01;
    #1;
    check("mid_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_err", num_of_errors, 0);
    check("mid_rst_cnt", {cnt_corrected, cnt_uncorrectable}, 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    ghost = 0;
    repeat (4) begin
      tick();
      if (out_valid) ghost++;
    end
    check("mid_no_ghost", ghost, 0);
    decode_single("post_rst", 32'h000000B1, 2'b00, 26'h00000B, 2'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
